// File: rtl/chime_pkg.sv
// Shared state/tone encodings, BCD constants and helpers for the chime sequencer.
// The SNOOZE state exists only when CHIME_SNOOZE_EN is defined.
package chime_pkg;

`ifdef CHIME_SNOOZE_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHIME,
    ST_RING_ON,
    ST_RING_OFF,
    ST_SNOOZE
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHIME,
    ST_RING_ON,
    ST_RING_OFF
  } state_t;
`endif

  typedef enum logic [1:0] {
    TONE_OFF,
    TONE_LOW,
    TONE_HIGH
  } tone_t;

  localparam logic [7:0] BCD_59 = 8'h59;
  localparam logic [7:0] BCD_00 = 8'h00;

  localparam logic [7:0] CHIME_LOW_S0 = 8'h51;
  localparam logic [7:0] CHIME_LOW_S1 = 8'h53;
  localparam logic [7:0] CHIME_LOW_S2 = 8'h55;
  localparam logic [7:0] CHIME_LOW_S3 = 8'h57;
  localparam logic [7:0] CHIME_HIGH_S = 8'h59;

  function automatic logic bcd_valid(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  // Tone the hourly chime asks for in a given minute/second, before enables.
  function automatic tone_t chime_tone(input logic [7:0] m, input logic [7:0] s);
    tone_t t;
    t = TONE_OFF;
    if (m == BCD_59) begin
      if (s == CHIME_HIGH_S) begin
        t = TONE_HIGH;
      end else if ((s == CHIME_LOW_S0) || (s == CHIME_LOW_S1) ||
                   (s == CHIME_LOW_S2) || (s == CHIME_LOW_S3)) begin
        t = TONE_LOW;
      end
    end
    return t;
  endfunction

endpackage

// File: rtl/chime_sequencer_tone_divider.sv
// Free-running square-wave generator: PHASE toggles every HALF_PERIOD clocks.
module tone_divider
  import chime_pkg::*;
#(
  parameter int HALF_PERIOD = 2
) (
  input  logic CP,
  input  logic RST,
  output logic PHASE
);

  localparam int CW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;

  logic [CW-1:0] count;

  always_ff @(posedge CP or posedge RST) begin
    if (RST) begin
      count <= '0;
      PHASE <= 1'b0;
    end else if (count == CW'(HALF_PERIOD - 1)) begin
      count <= '0;
      PHASE <= ~PHASE;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/chime_sequencer.sv
// Hourly chime plus NUM_ALARMS daily alarms driving a buzzer with internally generated tones.
// Define CHIME_SNOOZE_EN to build in the SNOOZE key and state.
module chime_sequencer
  import chime_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int LOW_HZ     = 500,
  parameter int HIGH_HZ    = 1000,
  parameter int NUM_ALARMS = 2,
  parameter int ALARM_SEC  = 60,
  parameter int SNOOZE_SEC = 300,
  localparam int ID_W      = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                     CP,
  input  logic                     RST,
  input  logic                     SEC_TICK,
  input  logic [7:0]               TIME_H,
  input  logic [7:0]               TIME_M,
  input  logic [7:0]               TIME_S,
  input  logic                     CHIME_EN,
  input  logic [NUM_ALARMS-1:0]    ALARM_EN,
  input  logic [16*NUM_ALARMS-1:0] ALARM_HM,
  input  logic                     STOP,
  input  logic                     SNOOZE,
  output logic                     AUDIO,
  output logic                     BUSY,
  output logic [ID_W-1:0]          ALARM_ID
);

  localparam int LOW_HALF  = CLK_HZ / (2 * LOW_HZ);
  localparam int HIGH_HALF = CLK_HZ / (2 * HIGH_HZ);
  localparam int RING_W    = $clog2(ALARM_SEC + 1);

  state_t            state;
  tone_t             tone;
  tone_t             chime_sel;
  logic              low_phase;
  logic              high_phase;
  logic [RING_W-1:0] ring_cnt;
  logic [RING_W-1:0] ring_next;
  logic              inhibit;
  logic              stop_q;
  logic              stop_rise;
  logic [NUM_ALARMS-1:0] en_q;
  logic              en_fall;
  logic              ringing;
  logic              time_valid;
  logic              trig_any;
  logic [ID_W-1:0]   trig_id;
  logic              chime_hit;

  tone_divider #(.HALF_PERIOD(LOW_HALF)) u_low_div (
    .CP    (CP),
    .RST   (RST),
    .PHASE (low_phase)
  );

  tone_divider #(.HALF_PERIOD(HIGH_HALF)) u_high_div (
    .CP    (CP),
    .RST   (RST),
    .PHASE (high_phase)
  );

`ifdef CHIME_SNOOZE_EN
  localparam int SNZ_W = $clog2(SNOOZE_SEC + 1);

  logic             snooze_q;
  logic             snooze_rise;
  logic [SNZ_W-1:0] snooze_cnt;
  logic [SNZ_W-1:0] snooze_next;

  assign snooze_rise = SNOOZE & ~snooze_q;
  assign snooze_next = snooze_cnt + SNZ_W'(1);
  assign ringing     = (state == ST_RING_ON) || (state == ST_RING_OFF) || (state == ST_SNOOZE);
`else
  logic unused_snooze;

  assign unused_snooze = SNOOZE | (SNOOZE_SEC < 0);
  assign ringing       = (state == ST_RING_ON) || (state == ST_RING_OFF);
`endif

  assign stop_rise = STOP & ~stop_q;
  assign ring_next = (ring_cnt == RING_W'(ALARM_SEC)) ? ring_cnt : ring_cnt + RING_W'(1);
  assign chime_sel = chime_tone(TIME_M, TIME_S);
  assign chime_hit = CHIME_EN && !inhibit && time_valid && (chime_sel != TONE_OFF);

  // Descending scan so the lowest-numbered triggering channel wins.
  always_comb begin
    time_valid = bcd_valid(TIME_H) && bcd_valid(TIME_M) && bcd_valid(TIME_S);
    trig_any   = 1'b0;
    trig_id    = '0;
    en_fall    = 1'b0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (time_valid && (TIME_S == BCD_00) && ALARM_EN[i] &&
          (ALARM_HM[16*i +: 16] == {TIME_H, TIME_M})) begin
        trig_any = 1'b1;
        trig_id  = ID_W'(i);
      end
    end
    for (int i = 0; i < NUM_ALARMS; i++) begin
      if (ALARM_ID == ID_W'(i)) begin
        en_fall = en_q[i] & ~ALARM_EN[i];
      end
    end
  end

  always_ff @(posedge CP or posedge RST) begin
    if (RST) begin
      state    <= ST_IDLE;
      tone     <= TONE_OFF;
      BUSY     <= 1'b0;
      ALARM_ID <= '0;
      ring_cnt <= '0;
      inhibit  <= 1'b0;
      stop_q   <= 1'b0;
      en_q     <= '0;
`ifdef CHIME_SNOOZE_EN
      snooze_q   <= 1'b0;
      snooze_cnt <= '0;
`endif
    end else begin
      stop_q <= STOP;
      en_q   <= ALARM_EN;
`ifdef CHIME_SNOOZE_EN
      snooze_q <= SNOOZE;
`endif
      if (ringing && (stop_rise || en_fall)) begin
        state <= ST_IDLE;
        tone  <= TONE_OFF;
        BUSY  <= 1'b0;
      end else if ((state == ST_CHIME) && stop_rise) begin
        state   <= ST_IDLE;
        tone    <= TONE_OFF;
        BUSY    <= 1'b0;
        inhibit <= 1'b1;
`ifdef CHIME_SNOOZE_EN
      end else if (((state == ST_RING_ON) || (state == ST_RING_OFF)) && snooze_rise) begin
        state      <= ST_SNOOZE;
        tone       <= TONE_OFF;
        snooze_cnt <= '0;
`endif
      end else if (SEC_TICK) begin
        // A chime cancelled by STOP stays muted for the rest of minute 59.
        if (TIME_M != BCD_59) begin
          inhibit <= 1'b0;
        end
        case (state)
          ST_IDLE, ST_CHIME: begin
            if (trig_any) begin
              state    <= ST_RING_ON;
              tone     <= TONE_HIGH;
              BUSY     <= 1'b1;
              ALARM_ID <= trig_id;
              ring_cnt <= '0;
            end else if (chime_hit) begin
              state <= ST_CHIME;
              tone  <= chime_sel;
              BUSY  <= 1'b1;
            end else begin
              state <= ST_IDLE;
              tone  <= TONE_OFF;
              BUSY  <= 1'b0;
            end
          end
          ST_RING_ON, ST_RING_OFF: begin
            ring_cnt <= ring_next;
            if (ring_next == RING_W'(ALARM_SEC)) begin
              state <= ST_IDLE;
              tone  <= TONE_OFF;
              BUSY  <= 1'b0;
            end else if (state == ST_RING_ON) begin
              state <= ST_RING_OFF;
              tone  <= TONE_OFF;
            end else begin
              state <= ST_RING_ON;
              tone  <= TONE_HIGH;
            end
          end
`ifdef CHIME_SNOOZE_EN
          ST_SNOOZE: begin
            if (snooze_next == SNZ_W'(SNOOZE_SEC)) begin
              state    <= ST_RING_ON;
              tone     <= TONE_HIGH;
              ring_cnt <= '0;
            end else begin
              snooze_cnt <= snooze_next;
            end
          end
`endif
          default: begin
            state <= ST_IDLE;
            tone  <= TONE_OFF;
            BUSY  <= 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge CP or posedge RST) begin
    if (RST) begin
      AUDIO <= 1'b0;
    end else begin
      AUDIO <= ((tone == TONE_LOW) && low_phase) || ((tone == TONE_HIGH) && high_phase);
    end
  end

endmodule

// File: tb/tb_chime_sequencer.sv
// Self-checking bench for chime_sequencer: directed sequences plus $urandom seconds,
// checked every cycle against a per-second behavioural model (snooze rules under CHIME_SNOOZE_EN).
module tb_chime_sequencer;

  localparam int CLK_HZ     = 10000;
  localparam int LOW_HZ     = 500;
  localparam int HIGH_HZ    = 1000;
  localparam int NUM_ALARMS = 2;
  localparam int ALARM_SEC  = 4;
  localparam int SNOOZE_SEC = 3;
  localparam int LOW_HALF   = 10;
  localparam int HIGH_HALF  = 5;
  localparam int SEC_CYC    = 30;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sec_tick = 1'b0;
  logic [7:0]  time_h = 8'h00;
  logic [7:0]  time_m = 8'h00;
  logic [7:0]  time_s = 8'h00;
  logic        chime_en = 1'b0;
  logic [1:0]  alarm_en = 2'b00;
  logic [31:0] alarm_hm = 32'h0;
  logic        stop = 1'b0;
  logic        snooze = 1'b0;
  logic        audio;
  logic        busy;
  logic [0:0]  alarm_id;

  int pass_count = 0;
  int check_count = 0;

  // Model: mode 0 quiet, 1 chiming, 2 alarm ringing, 3 snoozing.
  int   m_mode;
  int   m_ring_secs;
  int   m_snz_secs;
  int   m_id;
  int   m_chime;
  int   m_tone;
  bit   m_inhibit;
  bit   m_prev_stop;
  bit   m_prev_snz;
  logic [1:0] m_prev_en;
  longint edges;
  int   exp_audio;
  int   exp_busy;

  chime_sequencer #(
    .CLK_HZ     (CLK_HZ),
    .LOW_HZ     (LOW_HZ),
    .HIGH_HZ    (HIGH_HZ),
    .NUM_ALARMS (NUM_ALARMS),
    .ALARM_SEC  (ALARM_SEC),
    .SNOOZE_SEC (SNOOZE_SEC)
  ) dut (
    .CP       (clk),
    .RST      (rst),
    .SEC_TICK (sec_tick),
    .TIME_H   (time_h),
    .TIME_M   (time_m),
    .TIME_S   (time_s),
    .CHIME_EN (chime_en),
    .ALARM_EN (alarm_en),
    .ALARM_HM (alarm_hm),
    .STOP     (stop),
    .SNOOZE   (snooze),
    .AUDIO    (audio),
    .BUSY     (busy),
    .ALARM_ID (alarm_id)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got === exp) pass_count++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", tag, got, exp, $time);
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = 4'(v / 10);
    ones = 4'(v % 10);
    return {tens, ones};
  endfunction

  function automatic int bcd_val(input logic [7:0] v);
    if (v[7:4] > 4'd9 || v[3:0] > 4'd9) return -1;
    return int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic int chime_want(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    int ss;
    ss = bcd_val(s);
    if (bcd_val(h) < 0 || bcd_val(m) != 59 || ss < 0) return 0;
    if (ss == 59) return 2;
    if (ss >= 51 && ss <= 57 && (ss % 2) == 1) return 1;
    return 0;
  endfunction

  function automatic int alarm_winner();
    int th;
    int tm;
    logic [15:0] hm;
    th = bcd_val(time_h);
    tm = bcd_val(time_m);
    if (th < 0 || tm < 0 || bcd_val(time_s) != 0) return -1;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      hm = alarm_hm[16*i +: 16];
      if (alarm_en[i] && bcd_val(hm[15:8]) == th && bcd_val(hm[7:0]) == tm) return i;
    end
    return -1;
  endfunction

  task automatic modelReset();
    m_mode = 0; m_ring_secs = 0; m_snz_secs = 0; m_id = 0; m_chime = 0; m_tone = 0;
    m_inhibit = 0; m_prev_stop = 0; m_prev_snz = 0; m_prev_en = 2'b00;
    edges = 0; exp_audio = 0; exp_busy = 0;
  endtask

  // Tone dividers have toggled floor(edges/half) times since reset.
  task automatic modelEdge();
    bit stop_rise;
    bit en_fall;
    int win;
`ifdef CHIME_SNOOZE_EN
    bit snz_rise;
    snz_rise = snooze && !m_prev_snz;
`endif
    exp_audio = ((m_tone == 1) && ((edges / LOW_HALF) % 2 == 1)) ||
                ((m_tone == 2) && ((edges / HIGH_HALF) % 2 == 1));
    edges++;
    stop_rise = stop && !m_prev_stop;
    en_fall = m_prev_en[m_id] && !alarm_en[m_id];
    m_prev_stop = stop;
    m_prev_snz = snooze;
    m_prev_en = alarm_en;
    if (m_mode >= 2 && (stop_rise || en_fall)) begin
      m_mode = 0;
    end else if (m_mode == 1 && stop_rise) begin
      m_mode = 0;
      m_inhibit = 1;
`ifdef CHIME_SNOOZE_EN
    end else if (m_mode == 2 && snz_rise) begin
      m_mode = 3;
      m_snz_secs = 0;
`endif
    end else if (sec_tick) begin
      if (time_m != 8'h59) m_inhibit = 0;
      if (m_mode <= 1) begin
        win = alarm_winner();
        if (win >= 0) begin
          m_mode = 2; m_id = win; m_ring_secs = 0;
        end else if (chime_en && !m_inhibit && chime_want(time_h, time_m, time_s) != 0) begin
          m_mode = 1; m_chime = chime_want(time_h, time_m, time_s);
        end else begin
          m_mode = 0;
        end
      end else if (m_mode == 2) begin
        m_ring_secs++;
        if (m_ring_secs >= ALARM_SEC) m_mode = 0;
      end else begin
        m_snz_secs++;
        if (m_snz_secs >= SNOOZE_SEC) begin
          m_mode = 2; m_ring_secs = 0;
        end
      end
    end
    m_tone = (m_mode == 1) ? m_chime : ((m_mode == 2 && m_ring_secs % 2 == 0) ? 2 : 0);
    exp_busy = (m_mode != 0) ? 1 : 0;
  endtask

  task automatic runCycle();
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput("audio", audio, exp_audio);
    checkOutput("busy", busy, exp_busy);
    if (m_mode >= 2) checkOutput("alarm_id", alarm_id, m_id);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                               input int n_cyc, input int stop_cyc, input int snz_cyc);
    time_h = h; time_m = m; time_s = s;
    for (int c = 0; c < n_cyc; c++) begin
      sec_tick = (c == 0);
      if (c == stop_cyc) stop = 1'b1;
      if (c == snz_cyc) snooze = 1'b1;
      runCycle();
    end
    sec_tick = 1'b0;
    stop = 1'b0;
    snooze = 1'b0;
  endtask

  task automatic runRange(input logic [7:0] h, input logic [7:0] m, input int s0, input int s1);
    for (int s = s0; s <= s1; s++) applyStimulus(h, m, to_bcd(s), SEC_CYC, -1, -1);
  endtask

  initial begin
    logic [15:0] hm_pick;
    int r;
    int stop_c;
    int snz_c;

    modelReset();
    repeat (3) @(negedge clk);
    checkOutput("reset_audio", audio, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_id", alarm_id, 0);
    rst = 1'b0;

    // Hourly chime sweep across the hour boundary.
    chime_en = 1'b1;
    runRange(8'h12, 8'h59, 50, 59);
    runRange(8'h13, 8'h00, 0, 1);

    // Single alarm on channel 1.
    chime_en = 1'b0;
    alarm_hm = {16'h0730, 16'h0000};
    alarm_en = 2'b10;
    runRange(8'h07, 8'h29, 58, 59);
    runRange(8'h07, 8'h30, 0, 6);

    // Both channels match: channel 0 wins.
    alarm_hm = {16'h0730, 16'h0730};
    alarm_en = 2'b11;
    runRange(8'h07, 8'h29, 59, 59);
    runRange(8'h07, 8'h30, 0, 5);

    // Alarm holds priority over the chime seconds.
    alarm_hm = {16'h0000, 16'h1259};
    alarm_en = 2'b01;
    chime_en = 1'b1;
    applyStimulus(8'h12, 8'h59, 8'h00, SEC_CYC, -1, -1);
    runRange(8'h12, 8'h59, 51, 55);

    // STOP during the chime mutes the rest of minute 59 only.
    alarm_en = 2'b00;
    runRange(8'h12, 8'h59, 50, 52);
    applyStimulus(8'h12, 8'h59, 8'h53, SEC_CYC, 3, -1);
    runRange(8'h12, 8'h59, 54, 59);
    runRange(8'h13, 8'h00, 0, 0);
    runRange(8'h13, 8'h59, 50, 52);

    // ALARM_EN falling ends the ring.
    chime_en = 1'b0;
    alarm_hm = {16'h0730, 16'h0000};
    alarm_en = 2'b10;
    applyStimulus(8'h07, 8'h30, 8'h00, SEC_CYC, -1, -1);
    alarm_en = 2'b00;
    runRange(8'h07, 8'h30, 1, 2);

    // Invalid BCD time never triggers, even with equal raw codes.
    alarm_hm = {16'h073A, 16'h0A30};
    alarm_en = 2'b11;
    applyStimulus(8'h0A, 8'h30, 8'h00, SEC_CYC, -1, -1);
    applyStimulus(8'h07, 8'h3A, 8'h00, SEC_CYC, -1, -1);
    chime_en = 1'b1;
    applyStimulus(8'h1F, 8'h59, 8'h51, SEC_CYC, -1, -1);
    chime_en = 1'b0;

    // Asynchronous reset while ringing with an audible phase.
    alarm_hm = {16'h0730, 16'h0000};
    alarm_en = 2'b10;
    runRange(8'h07, 8'h29, 59, 59);
    applyStimulus(8'h07, 8'h30, 8'h00, 1, -1, -1);
    for (int i = 0; i < 12 && exp_audio == 0; i++) runCycle();
    checkOutput("pre_reset_audio", audio, 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst_audio", audio, 0);
    checkOutput("async_rst_busy", busy, 0);
    checkOutput("async_rst_id", alarm_id, 0);
    #1 rst = 1'b0;
    modelReset();
    runRange(8'h07, 8'h30, 1, 3);

`ifdef CHIME_SNOOZE_EN
    // Snooze at ring second 1, ring resumes, then STOP while snoozing.
    alarm_hm = {16'h0730, 16'h0000};
    alarm_en = 2'b10;
    applyStimulus(8'h07, 8'h30, 8'h00, SEC_CYC, -1, -1);
    applyStimulus(8'h07, 8'h30, 8'h01, SEC_CYC, -1, 10);
    runRange(8'h07, 8'h30, 2, 5);
    applyStimulus(8'h07, 8'h30, 8'h06, SEC_CYC, -1, 8);
    applyStimulus(8'h07, 8'h30, 8'h07, SEC_CYC, 5, -1);
    runRange(8'h07, 8'h30, 8, 9);
`endif

    // Randomised seconds around the alarm and chime hot spots.
    alarm_hm = {16'h0730, 16'h1259};
    alarm_en = 2'b11;
    for (int n = 0; n < 90; n++) begin
      r = $urandom_range(0, 4);
      case (r)
        0: hm_pick = 16'h0730;
        1: hm_pick = 16'h1259;
        2: hm_pick = 16'h1359;
        3: hm_pick = 16'h0A30;
        default: hm_pick = {to_bcd($urandom_range(0, 23)), to_bcd($urandom_range(0, 59))};
      endcase
      if ($urandom_range(0, 5) == 0) alarm_en = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) chime_en = ~chime_en;
      stop_c = ($urandom_range(0, 5) == 0) ? int'($urandom_range(2, 27)) : -1;
      snz_c = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 27)) : -1;
      r = $urandom_range(0, 3);
      if (r == 0) applyStimulus(hm_pick[15:8], hm_pick[7:0], 8'h00, SEC_CYC, stop_c, snz_c);
      else if (r == 1) applyStimulus(hm_pick[15:8], hm_pick[7:0], to_bcd($urandom_range(50, 59)), SEC_CYC, stop_c, snz_c);
      else applyStimulus(hm_pick[15:8], hm_pick[7:0], to_bcd($urandom_range(0, 59)), SEC_CYC, stop_c, snz_c);
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/chime_sequencer.md
# chime_sequencer

Parametrised audio sequencer for the digital clock. Generates the hourly chime and up to NUM_ALARMS independent daily alarms, and synthesises its own low/high square-wave tones from the system clock instead of taking external 500 Hz/1 kHz inputs. Sits between the BCD timekeeper (time, one-pulse-per-second tick) and the buzzer driver. Alarms take priority over the chime, and a stop key cancels the current sound.

## Interface
- CLK_HZ, 50_000_000, system clock frequency
- LOW_HZ, 500, low tone frequency
- HIGH_HZ, 1000, high tone frequency
- NUM_ALARMS, 2, alarm channel count, 1..8
- ALARM_SEC, 60, maximum ring time in seconds before automatic stop
- SNOOZE_SEC, 300, snooze interval in seconds (used only with snooze compiled in)
- CP  in  1  system clock, rising edge
- RST  in  1  asynchronous reset, active high
- SEC_TICK  in  1  one-cycle pulse per second; TIME_* already hold the new second in that cycle
- TIME_H, TIME_M, TIME_S  in  8 each  current time, packed BCD
- CHIME_EN  in  1  enables the hourly chime
- ALARM_EN  in  NUM_ALARMS  per-channel enable
- ALARM_HM  in  16*NUM_ALARMS  per-channel {HH,MM} BCD; channel i at bits [16i+15:16i]
- STOP  in  1  level, synchronised upstream; acts on rising edge
- SNOOZE  in  1  level, rising edge (snooze builds only)
- AUDIO  out  1  tone output
- BUSY  out  1  any sound sequence in progress
- ALARM_ID  out  $clog2(NUM_ALARMS) (min 1)  ringing channel, valid when BUSY in an alarm state

## Operation
- Tone dividers: half-period counts are CLK_HZ/(2*LOW_HZ) and CLK_HZ/(2*HIGH_HZ), integer division. Each divider toggles its phase when the count reaches half-period−1, then wraps to 0. Dividers run freely from reset.
- All time decisions are taken only in SEC_TICK cycles. The selected tone is held until the next SEC_TICK.
- Chime: when CHIME_EN=1 and TIME_M=59, TIME_S 51/53/55/57 selects the low tone and TIME_S 59 selects the high tone. Every other second is silent.
- Alarm trigger: channel i triggers when ALARM_EN[i]=1, {TIME_H,TIME_M}=ALARM_HM[i] and TIME_S=00. If several channels trigger in the same tick, the lowest index wins.
- States: IDLE, CHIME, RING_ON, RING_OFF, SNOOZE (snooze builds only).
- IDLE→CHIME on a chime second; IDLE or CHIME→RING_ON on an alarm trigger, so an alarm pre-empts the chime.
- CHIME→IDLE on a silent tick.
- RING_ON (high tone) and RING_OFF (silent) alternate on each tick.
- Ring→IDLE on a STOP edge, on ALARM_EN[ALARM_ID] falling, or after ALARM_SEC ticks.
- A new trigger while ringing is ignored.
- STOP during CHIME silences the output and inhibits the chime until TIME_M≠59.
- Invalid BCD on TIME_* never matches. Channels compare BCD directly, with no conversion.
- Ring-second counter width is $clog2(ALARM_SEC+1) and saturates.

## Timing
- Reset values: AUDIO=0, BUSY=0, ALARM_ID=0, state IDLE, dividers and phases 0, chime inhibit clear.
- State and tone select update on the CP edge that samples SEC_TICK=1.
- AUDIO is registered: AUDIO = selected phase & enable, one cycle after the select changes.
- Sound starts 2 cycles after the SEC_TICK cycle.
- A STOP edge silences AUDIO within 2 cycles, independent of SEC_TICK.
- BUSY is registered with the state and is high in every state except IDLE.
- Reset mid-sequence: AUDIO drops asynchronously, and the pending alarm is discarded.

## Configuration
- CHIME_SNOOZE_EN defined: a SNOOZE edge in RING_ON/RING_OFF moves to SNOOZE (silent, BUSY=1, ALARM_ID held).
  - After SNOOZE_SEC ticks the block returns to RING_ON, and the ring-second counter reloads.
  - STOP in SNOOZE→IDLE.
- CHIME_SNOOZE_EN undefined: the SNOOZE port exists but is ignored, the SNOOZE state and its counter are absent, and SNOOZE_SEC is unused.

## Structure
- Package chime_pkg holds:
  - state enum;
  - BCD constants 8'h59, 8'h00;
  - chime pattern seconds 51/53/55/57 (low) and 59 (high);
  - tone-select enum OFF/LOW/HIGH.
- Sub-module tone_divider (parameter HALF_PERIOD; ports CP, RST, PHASE) is instantiated twice.

## Test plan
Bench uses CLK_HZ=10000, LOW_HZ=500, HIGH_HZ=1000, NUM_ALARMS=2, ALARM_SEC=4, SNOOZE_SEC=3.
- Chime: sweep 12:59:50..13:00:01 with CHIME_EN=1 → low tone (10-cycle half period) at :51/:53/:55/:57, high tone (5-cycle half period) at :59, silent elsewhere and at 13:00:00.
- Alarm: ALARM_HM[1]=0x0730, enabled, time 07:30:00 → ALARM_ID=1, high-tone beeps at seconds 0 and 2, silent at 1 and 3, IDLE at 07:30:04, BUSY drops.
- Priority: both channels set to 0x0730 → ALARM_ID=0. Alarm at 12:59:00 with CHIME_EN → ring pattern persists through :51, with no low tone.
- STOP at 12:59:53 during the chime → AUDIO=0 within 2 cycles and no tone at :55/:57/:59. At the next hour's :51 the chime sounds again.
- Reset asserted during RING_ON → AUDIO=0 and BUSY=0 immediately, with no ring after release.
- With CHIME_SNOOZE_EN: SNOOZE at ring second 1 → silent for 3 ticks, then RING_ON with the same ALARM_ID. STOP in SNOOZE → IDLE.
